// File: rtl/preg_free_list.sv
`default_nettype none
// ============================================================================
// Module   : preg_free_list
// Brief    : Circular free list of physical register tags for rename, with
//            dual allocate, dual reclaim and flush rewind to the commit point.
// Revision : 1.0
// ============================================================================
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  alloc_req1,
  input  logic                                  alloc_req2,
  output logic                                  alloc_grant1,
  output logic                                  alloc_grant2,
  output logic [$clog2(NUM_PREGS)-1:0]          alloc_preg1,
  output logic [$clog2(NUM_PREGS)-1:0]          alloc_preg2,
  input  logic                                  free1,
  input  logic                                  free2,
  input  logic [$clog2(NUM_PREGS)-1:0]          free_preg1,
  input  logic [$clog2(NUM_PREGS)-1:0]          free_preg2,
  input  logic                                  retire_alloc1,
  input  logic                                  retire_alloc2,
  input  logic                                  flush,
  output logic [$clog2(NUM_PREGS-NUM_AREGS):0]  free_count,
  output logic                                  empty,
  output logic                                  overflow_err
);

  localparam int c_TAG_W = $clog2(NUM_PREGS);
  localparam int c_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int c_PTR_W = $clog2(c_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [c_TAG_W-1:0] r_entry [c_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_PTR_W-1:0] r_commit;
  logic [c_CNT_W-1:0] r_count;
  logic               r_empty;
  logic               r_overflow;

  logic               w_grant1;
  logic               w_grant2;
  logic               w_valid1;
  logic               w_valid2;
  logic               w_acc1;
  logic               w_acc2;
  logic               w_drop;
  logic [c_CNT_W-1:0] w_n_grant;
  logic [c_CNT_W-1:0] w_n_acc;
  logic [c_CNT_W-1:0] w_base;
  logic [c_CNT_W-1:0] w_count_next;
  logic [c_PTR_W-1:0] w_n_ret;
  logic [c_PTR_W-1:0] w_slot2;
  logic [c_PTR_W-1:0] w_tail_next;
  logic [c_PTR_W-1:0] w_commit_next;
  logic [c_PTR_W-1:0] w_head_next;
  logic [c_PTR_W-1:0] w_diff;

  always_comb begin
    w_grant1  = !flush && alloc_req1 &&
                (alloc_req2 ? (r_count >= c_CNT_W'(2)) : (r_count != '0));
    w_grant2  = w_grant1 && alloc_req2;
    w_n_grant = c_CNT_W'(w_grant1) + c_CNT_W'(w_grant2);
    // Capacity check uses the post-grant occupancy so net count never exceeds depth
    w_base    = r_count - w_n_grant;
    w_valid1  = free1 && (free_preg1 != '0);
    w_valid2  = free2 && (free_preg2 != '0);
    w_acc1    = w_valid1 && (w_base < c_CNT_W'(c_DEPTH));
    w_acc2    = w_valid2 && ((w_base + c_CNT_W'(w_acc1)) < c_CNT_W'(c_DEPTH));
    w_drop    = (w_valid1 && !w_acc1) || (w_valid2 && !w_acc2);
    w_n_acc   = c_CNT_W'(w_acc1) + c_CNT_W'(w_acc2);

    w_slot2       = r_tail + c_PTR_W'(w_acc1);
    w_tail_next   = r_tail + c_PTR_W'(w_n_acc);
    w_n_ret       = c_PTR_W'(retire_alloc1) + c_PTR_W'(retire_alloc2);
    w_commit_next = r_commit + w_n_ret;
    w_head_next   = flush ? w_commit_next : (r_head + c_PTR_W'(w_n_grant));
    w_diff        = w_tail_next - w_head_next;

    // Equal pointers after a flush mean full unless nothing was ever available
    if (!flush)
      w_count_next = r_count + w_n_acc - w_n_grant;
    else if (w_diff != '0)
      w_count_next = c_CNT_W'(w_diff);
    else if ((r_count != '0) || (w_n_acc != '0))
      w_count_next = c_CNT_W'(c_DEPTH);
    else
      w_count_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++)
        r_entry[i] <= c_TAG_W'(NUM_AREGS + i);
      r_head     <= '0;
      r_tail     <= '0;
      r_commit   <= '0;
      r_count    <= c_CNT_W'(c_DEPTH);
      r_empty    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_acc1)
        r_entry[r_tail] <= free_preg1;
      if (w_acc2)
        r_entry[w_slot2] <= free_preg2;
      r_head   <= w_head_next;
      r_tail   <= w_tail_next;
      r_commit <= w_commit_next;
      r_count  <= w_count_next;
      r_empty  <= (w_count_next == '0);
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  assign alloc_grant1 = w_grant1;
  assign alloc_grant2 = w_grant2;
  assign alloc_preg1  = r_entry[r_head];
  assign alloc_preg2  = r_entry[r_head + c_PTR_W'(1)];
  assign free_count   = r_count;
  assign empty        = r_empty;
  assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_preg_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_preg_free_list
// Brief    : Directed scenarios plus randomized traffic against a queue model
//            of the free list, speculative allocations and retired tags.
// Revision : 1.0
// ============================================================================
module tb_preg_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req1, alloc_req2;
  logic       alloc_grant1, alloc_grant2;
  logic [5:0] alloc_preg1, alloc_preg2;
  logic       free1, free2;
  logic [5:0] free_preg1, free_preg2;
  logic       retire_alloc1, retire_alloc2;
  logic       flush;
  logic [5:0] free_count;
  logic       empty, overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  preg_free_list #(.NUM_PREGS(64), .NUM_AREGS(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_req1(alloc_req1), .alloc_req2(alloc_req2),
    .alloc_grant1(alloc_grant1), .alloc_grant2(alloc_grant2),
    .alloc_preg1(alloc_preg1), .alloc_preg2(alloc_preg2),
    .free1(free1), .free2(free2),
    .free_preg1(free_preg1), .free_preg2(free_preg2),
    .retire_alloc1(retire_alloc1), .retire_alloc2(retire_alloc2),
    .flush(flush),
    .free_count(free_count), .empty(empty), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    alloc_req1 = 0; alloc_req2 = 0; free1 = 0; free2 = 0;
    free_preg1 = 0; free_preg2 = 0; retire_alloc1 = 0; retire_alloc2 = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_in(); rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset(); #2;
    n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL reset_count: got %0d expected 32", free_count); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %b expected 0", empty); end
    n_checks++; if (alloc_preg1 !== 6'd32) begin n_fail++; $display("FAIL reset_preg1: got %0d expected 32", alloc_preg1); end
    n_checks++; if (alloc_preg2 !== 6'd33) begin n_fail++; $display("FAIL reset_preg2: got %0d expected 33", alloc_preg2); end
    n_checks++; if ({alloc_grant1, alloc_grant2} !== 2'b00) begin n_fail++; $display("FAIL reset_grants: got %b expected 00", {alloc_grant1, alloc_grant2}); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow_err); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 16; k++) begin
      alloc_req1 = 1; alloc_req2 = 1; #2;
      n_checks++; if ({alloc_grant1, alloc_grant2} !== 2'b11) begin n_fail++; $display("FAIL drain_grants[%0d]: got %b expected 11", k, {alloc_grant1, alloc_grant2}); end
      n_checks++; if (alloc_preg1 !== 6'(32 + 2 * k)) begin n_fail++; $display("FAIL drain_preg1[%0d]: got %0d expected %0d", k, alloc_preg1, 32 + 2 * k); end
      n_checks++; if (alloc_preg2 !== 6'(33 + 2 * k)) begin n_fail++; $display("FAIL drain_preg2[%0d]: got %0d expected %0d", k, alloc_preg2, 33 + 2 * k); end
      tick();
    end
    clear_in();
    n_checks++; if (free_count !== 6'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", free_count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
    alloc_req1 = 1; #2;
    n_checks++; if (alloc_grant1 !== 1'b0) begin n_fail++; $display("FAIL drain_nogrant: got %b expected 0", alloc_grant1); end
    tick(); clear_in();
  endtask

  task automatic test_free_no_bypass();
    free1 = 1; free_preg1 = 6'd40; alloc_req1 = 1; #2;
    n_checks++; if (alloc_grant1 !== 1'b0) begin n_fail++; $display("FAIL bypass_same_cycle: got %b expected 0", alloc_grant1); end
    tick(); free1 = 0; #2;
    n_checks++; if (alloc_grant1 !== 1'b1) begin n_fail++; $display("FAIL bypass_next_grant: got %b expected 1", alloc_grant1); end
    n_checks++; if (alloc_preg1 !== 6'd40) begin n_fail++; $display("FAIL bypass_next_tag: got %0d expected 40", alloc_preg1); end
    tick(); clear_in();
    n_checks++; if (free_count !== 6'd0) begin n_fail++; $display("FAIL bypass_count: got %0d expected 0", free_count); end
  endtask

  task automatic test_count_one();
    free1 = 1; free_preg1 = 6'd41; tick(); clear_in();
    n_checks++; if (free_count !== 6'd1) begin n_fail++; $display("FAIL one_count: got %0d expected 1", free_count); end
    alloc_req1 = 1; alloc_req2 = 1; #2;
    n_checks++; if ({alloc_grant1, alloc_grant2} !== 2'b00) begin n_fail++; $display("FAIL one_dual_grants: got %b expected 00", {alloc_grant1, alloc_grant2}); end
    tick();
    n_checks++; if (free_count !== 6'd1) begin n_fail++; $display("FAIL one_hold: got %0d expected 1", free_count); end
    alloc_req2 = 0; #2;
    n_checks++; if (alloc_grant1 !== 1'b1 || alloc_preg1 !== 6'd41) begin n_fail++; $display("FAIL one_single: got grant %b tag %0d expected grant 1 tag 41", alloc_grant1, alloc_preg1); end
    tick(); clear_in();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 15; k++) begin alloc_req1 = 1; alloc_req2 = 1; tick(); end
    alloc_req2 = 0; tick(); clear_in();
    free1 = 1; free_preg1 = 6'd7; free2 = 1; free_preg2 = 6'd9; tick(); clear_in();
    n_checks++; if (free_count !== 6'd3) begin n_fail++; $display("FAIL wrap_count: got %0d expected 3", free_count); end
    alloc_req1 = 1; alloc_req2 = 1; #2;
    n_checks++; if (alloc_preg1 !== 6'd63 || alloc_preg2 !== 6'd7) begin n_fail++; $display("FAIL wrap_tags: got %0d,%0d expected 63,7", alloc_preg1, alloc_preg2); end
    n_checks++; if ({alloc_grant1, alloc_grant2} !== 2'b11) begin n_fail++; $display("FAIL wrap_grants: got %b expected 11", {alloc_grant1, alloc_grant2}); end
    tick(); clear_in(); #2;
    n_checks++; if (alloc_preg1 !== 6'd9 || free_count !== 6'd1) begin n_fail++; $display("FAIL wrap_after: got tag %0d count %0d expected 9,1", alloc_preg1, free_count); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req1 = 1; alloc_req2 = 1; tick(); tick(); clear_in();
    retire_alloc1 = 1; tick(); tick(); clear_in();
    flush = 1; alloc_req1 = 1; #2;
    n_checks++; if (alloc_grant1 !== 1'b0) begin n_fail++; $display("FAIL flush_grant_forced: got %b expected 0", alloc_grant1); end
    tick(); clear_in();
    n_checks++; if (alloc_preg1 !== 6'd34 || alloc_preg2 !== 6'd35) begin n_fail++; $display("FAIL flush_head: got %0d,%0d expected 34,35", alloc_preg1, alloc_preg2); end
    n_checks++; if (free_count !== 6'd30) begin n_fail++; $display("FAIL flush_count: got %0d expected 30", free_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    free1 = 1; free_preg1 = 6'd5; tick(); clear_in();
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
    n_checks++; if (free_count !== 6'd32 || alloc_preg1 !== 6'd32) begin n_fail++; $display("FAIL ovf_dropped: got count %0d tag %0d expected 32,32", free_count, alloc_preg1); end
    tick(); tick(); tick();
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
    // rst must win over pending requests, frees and flush
    rst = 1; alloc_req1 = 1; alloc_req2 = 1; flush = 1; free1 = 1; free_preg1 = 6'd3;
    tick(); clear_in(); rst = 0; #2;
    n_checks++; if (overflow_err !== 1'b0 || free_count !== 6'd32 || alloc_preg1 !== 6'd32) begin n_fail++; $display("FAIL rst_priority: got ovf %b count %0d tag %0d expected 0,32,32", overflow_err, free_count, alloc_preg1); end
    alloc_req1 = 1; tick(); clear_in();
    free1 = 1; free_preg1 = 6'd0; tick(); clear_in();
    n_checks++; if (free_count !== 6'd31 || overflow_err !== 1'b0) begin n_fail++; $display("FAIL tag0_ignored: got count %0d ovf %b expected 31,0", free_count, overflow_err); end
  endtask

  task automatic test_random();
    int freeq[$];
    int spec[$];
    int pool[$];
    do_reset();
    for (int i = 0; i < 32; i++) freeq.push_back(32 + i);
    for (int i = 1; i < 32; i++) pool.push_back(i);
    for (int cyc = 0; cyc < 400; cyc++) begin
      int nret, n, idx, maxret;
      bit r1, r2, fl, eg1, eg2;
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      maxret = (spec.size() >= 2) ? 2 : spec.size();
      nret = $urandom_range(0, maxret);
      fl = ($urandom_range(0, 15) == 0) && !(freeq.size() == 0 && nret == 0);
      clear_in();
      alloc_req1 = r1; alloc_req2 = r2; flush = fl;
      retire_alloc1 = (nret >= 1); retire_alloc2 = (nret == 2);
      if (nret >= 1) begin
        idx = $urandom_range(0, pool.size() - 1); free1 = 1; free_preg1 = 6'(pool[idx]); pool.delete(idx);
      end else if ($urandom_range(0, 7) == 0) begin
        free1 = 1; free_preg1 = 6'd0;
      end
      if (nret == 2) begin
        idx = $urandom_range(0, pool.size() - 1); free2 = 1; free_preg2 = 6'(pool[idx]); pool.delete(idx);
      end
      #2;
      n = freeq.size();
      eg1 = !fl && r1 && (r2 ? (n >= 2) : (n >= 1));
      eg2 = eg1 && r2;
      n_checks++; if ({alloc_grant1, alloc_grant2} !== {eg1, eg2}) begin n_fail++; $display("FAIL rand_grants[%0d]: got %b expected %b", cyc, {alloc_grant1, alloc_grant2}, {eg1, eg2}); end
      if (eg1) begin
        n_checks++; if (alloc_preg1 !== 6'(freeq[0])) begin n_fail++; $display("FAIL rand_preg1[%0d]: got %0d expected %0d", cyc, alloc_preg1, freeq[0]); end
      end
      if (eg2) begin
        n_checks++; if (alloc_preg2 !== 6'(freeq[1])) begin n_fail++; $display("FAIL rand_preg2[%0d]: got %0d expected %0d", cyc, alloc_preg2, freeq[1]); end
      end
      if (eg1) spec.push_back(freeq.pop_front());
      if (eg2) spec.push_back(freeq.pop_front());
      repeat (nret) pool.push_back(spec.pop_front());
      if (free1 && free_preg1 != 0) freeq.push_back(int'(free_preg1));
      if (free2 && free_preg2 != 0) freeq.push_back(int'(free_preg2));
      if (fl) while (spec.size() > 0) freeq.push_front(spec.pop_back());
      tick();
      n_checks++; if (free_count !== 6'(freeq.size()) || empty !== (freeq.size() == 0)) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d/%b expected %0d", cyc, free_count, empty, freeq.size()); end
    end
    clear_in();
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL rand_ovf: got %b expected 0", overflow_err); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in(); rst = 1;
    test_reset();
    test_drain();
    test_free_no_bypass();
    test_count_one();
    test_wrap();
    test_flush();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
